// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - 5-stage pipeline stall/flush/bubble control and halt drain sequencer
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_controller #(
  parameter int FORWARDING   = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             of_valid,
  input  logic [3:0]       of_rs1,
  input  logic             of_rs1_used,
  input  logic [3:0]       of_rs2,
  input  logic             of_rs2_used,
  input  logic             of_is_halt,
  input  logic             ex_isWb,
  input  logic [3:0]       ex_rd,
  input  logic             ex_isLd,
  input  logic             ma_isWb,
  input  logic [3:0]       ma_rd,
  input  logic             is_Branch_Taken,
  output logic             stall_pc,
  output logic             stall_if_of,
  output logic             flush_if_of,
  output logic             bubble_of_ex,
  output logic             isDataInterLock,
  output logic             isLastInstruction,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] perf_stall_cycles,
  output logic [CNT_W-1:0] perf_flush_count,
`endif
  output logic [1:0]       ctrl_state
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_cnt_nxt;
  logic          ex_match, ma_match, hz;

  assign ex_match = of_valid & ((of_rs1_used & (of_rs1 == ex_rd)) |
                                (of_rs2_used & (of_rs2 == ex_rd)));
  assign ma_match = of_valid & ((of_rs1_used & (of_rs1 == ma_rd)) |
                                (of_rs2_used & (of_rs2 == ma_rd)));

  // RW never conflicts: the register file writes in the first half-cycle.
  always_comb begin
    if (FORWARDING != 0) hz = ex_isWb & ex_isLd & ex_match;
    else                 hz = (ex_isWb & ex_match) | (ma_isWb & ma_match);
  end

  always_comb begin
    state_nxt       = state;
    drain_cnt_nxt   = drain_cnt;
    stall_pc        = 1'b0;
    stall_if_of     = 1'b0;
    flush_if_of     = 1'b0;
    bubble_of_ex    = 1'b0;
    isDataInterLock = 1'b0;
    case (state)
      ST_RUN: begin
        if (is_Branch_Taken) begin
          flush_if_of  = 1'b1;
          bubble_of_ex = 1'b1;
        end else if (hz) begin
          stall_pc        = 1'b1;
          stall_if_of     = 1'b1;
          bubble_of_ex    = 1'b1;
          isDataInterLock = 1'b1;
        end else if (of_is_halt && of_valid) begin
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = DW'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        stall_pc    = 1'b1;
        flush_if_of = 1'b1;
        if (drain_cnt == '0) state_nxt = ST_HALTED;
        else                 drain_cnt_nxt = drain_cnt - DW'(1);
      end
      ST_HALTED: begin
        stall_pc    = 1'b1;
        stall_if_of = 1'b1;
        flush_if_of = 1'b1;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_RUN;
      drain_cnt         <= '0;
      isLastInstruction <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      if (state_nxt == ST_HALTED) isLastInstruction <= 1'b1;
    end
  end

  assign ctrl_state = state;

`ifdef HAZARD_PERF_CNT_EN
  // Both counters saturate; they only move in RUN, so they freeze once draining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (isDataInterLock && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + CNT_W'(1);
      if ((state == ST_RUN) && is_Branch_Taken && (perf_flush_count != '1))
        perf_flush_count <= perf_flush_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed-vector bench for both FORWARDING builds of pipeline_hazard_controller
module tb_pipeline_hazard_controller;

  localparam int CNT_W = 16;

  // Packed output view: {stall_pc, stall_if_of, flush, bubble, interlock, last, state[1:0]}
  localparam logic [7:0] P_IDLE   = 8'b0000_0000;
  localparam logic [7:0] P_STALL  = 8'b1101_1000;
  localparam logic [7:0] P_BRANCH = 8'b0011_0000;
  localparam logic [7:0] P_DRAIN  = 8'b1010_0001;
  localparam logic [7:0] P_HALTED = 8'b1110_0110;

  logic       clk = 1'b0;
  logic       reset;
  logic       of_valid, of_rs1_used, of_rs2_used, of_is_halt;
  logic [3:0] of_rs1, of_rs2, ex_rd, ma_rd;
  logic       ex_isWb, ex_isLd, ma_isWb, is_Branch_Taken;

  logic       f_stall_pc, f_stall_if_of, f_flush, f_bubble, f_il, f_last;
  logic [1:0] f_state;
  logic       n_stall_pc, n_stall_if_of, n_flush, n_bubble, n_il, n_last;
  logic [1:0] n_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] f_perf_stall, f_perf_flush, n_perf_stall, n_perf_flush;
`endif

  logic [7:0] f_out, n_out;
  assign f_out = {f_stall_pc, f_stall_if_of, f_flush, f_bubble, f_il, f_last, f_state};
  assign n_out = {n_stall_pc, n_stall_if_of, n_flush, n_bubble, n_il, n_last, n_state};

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.FORWARDING(1), .DRAIN_CYCLES(3), .CNT_W(CNT_W)) u_fwd (
    .clk(clk), .reset(reset), .of_valid(of_valid), .of_rs1(of_rs1), .of_rs1_used(of_rs1_used),
    .of_rs2(of_rs2), .of_rs2_used(of_rs2_used), .of_is_halt(of_is_halt), .ex_isWb(ex_isWb),
    .ex_rd(ex_rd), .ex_isLd(ex_isLd), .ma_isWb(ma_isWb), .ma_rd(ma_rd),
    .is_Branch_Taken(is_Branch_Taken), .stall_pc(f_stall_pc), .stall_if_of(f_stall_if_of),
    .flush_if_of(f_flush), .bubble_of_ex(f_bubble), .isDataInterLock(f_il),
    .isLastInstruction(f_last),
`ifdef HAZARD_PERF_CNT_EN
    .perf_stall_cycles(f_perf_stall), .perf_flush_count(f_perf_flush),
`endif
    .ctrl_state(f_state)
  );

  pipeline_hazard_controller #(.FORWARDING(0), .DRAIN_CYCLES(3), .CNT_W(CNT_W)) u_nofwd (
    .clk(clk), .reset(reset), .of_valid(of_valid), .of_rs1(of_rs1), .of_rs1_used(of_rs1_used),
    .of_rs2(of_rs2), .of_rs2_used(of_rs2_used), .of_is_halt(of_is_halt), .ex_isWb(ex_isWb),
    .ex_rd(ex_rd), .ex_isLd(ex_isLd), .ma_isWb(ma_isWb), .ma_rd(ma_rd),
    .is_Branch_Taken(is_Branch_Taken), .stall_pc(n_stall_pc), .stall_if_of(n_stall_if_of),
    .flush_if_of(n_flush), .bubble_of_ex(n_bubble), .isDataInterLock(n_il),
    .isLastInstruction(n_last),
`ifdef HAZARD_PERF_CNT_EN
    .perf_stall_cycles(n_perf_stall), .perf_flush_count(n_perf_flush),
`endif
    .ctrl_state(n_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    of_valid = 0; of_rs1 = 0; of_rs1_used = 0; of_rs2 = 0; of_rs2_used = 0; of_is_halt = 0;
    ex_isWb = 0; ex_rd = 0; ex_isLd = 0; ma_isWb = 0; ma_rd = 0; is_Branch_Taken = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_r3();
    clear_in();
    ex_isWb = 1; ex_isLd = 1; ex_rd = 4'd3;
    of_valid = 1; of_rs1 = 4'd3; of_rs1_used = 1;
  endtask

  initial begin
    clear_in();
    reset = 1;
    step();
    check("reset_fwd", 32'(f_out), 32'(P_IDLE));
    check("reset_nofwd", 32'(n_out), 32'(P_IDLE));
    reset = 0;
    step();

    // Load-use: one stall with forwarding; the load then sits in MA.
    load_use_r3();
    #1;
    check("lu_fwd_stall", 32'(f_out), 32'(P_STALL));
    check("lu_nofwd_stall", 32'(n_out), 32'(P_STALL));
    step();
    ex_isWb = 0; ex_isLd = 0; ma_isWb = 1; ma_rd = 4'd3;
    #1;
    check("lu_fwd_release", 32'(f_out), 32'(P_IDLE));
    check("lu_nofwd_ma_stall", 32'(n_out), 32'(P_STALL));
    step();

    // ALU producer of r5 in EX then MA, consumed through rs2.
    clear_in();
    ex_isWb = 1; ex_rd = 4'd5; of_valid = 1; of_rs2 = 4'd5; of_rs2_used = 1;
    #1;
    check("alu_fwd_ex", 32'(f_out), 32'(P_IDLE));
    check("alu_nofwd_ex", 32'(n_out), 32'(P_STALL));
    step();
    ex_isWb = 0; ma_isWb = 1; ma_rd = 4'd5;
    #1;
    check("alu_fwd_ma", 32'(f_out), 32'(P_IDLE));
    check("alu_nofwd_ma", 32'(n_out), 32'(P_STALL));
    step();
    ma_isWb = 0;
    #1;
    check("alu_nofwd_rw", 32'(n_out), 32'(P_IDLE));

    // Match gated by of_valid and by the used flags.
    load_use_r3(); of_valid = 0;
    #1;
    check("invalid_of_fwd", 32'(f_out), 32'(P_IDLE));
    load_use_r3(); of_rs1_used = 0;
    #1;
    check("unused_rs1_nofwd", 32'(n_out), 32'(P_IDLE));

    // Branch wins over a simultaneous hazard.
    load_use_r3(); is_Branch_Taken = 1;
    #1;
    check("br_hz_fwd", 32'(f_out), 32'(P_BRANCH));
    check("br_hz_nofwd", 32'(n_out), 32'(P_BRANCH));
    step();

    // Halt squashed by a branch, then halt blocked by a hazard.
    clear_in(); of_valid = 1; of_is_halt = 1; is_Branch_Taken = 1;
    step();
    check("halt_br_fwd", 32'(f_out), 32'(P_BRANCH));
    check("halt_br_nofwd", 32'(n_out), 32'(P_BRANCH));
    load_use_r3(); of_is_halt = 1;
    step();
    check("halt_hz_fwd", 32'(f_out), 32'(P_STALL));
    check("halt_hz_nofwd", 32'(n_out), 32'(P_STALL));

    // Clean halt: three DRAIN cycles, then sticky HALTED.
    clear_in(); of_valid = 1; of_is_halt = 1;
    #1;
    check("halt_issue_fwd", 32'(f_out), 32'(P_IDLE));
    step();
    load_use_r3(); is_Branch_Taken = 1;
    #1;
    check("drain1_fwd", 32'(f_out), 32'(P_DRAIN));
    check("drain1_nofwd", 32'(n_out), 32'(P_DRAIN));
    step();
    check("drain2_fwd", 32'(f_out), 32'(P_DRAIN));
    clear_in();
    step();
    check("drain3_fwd", 32'(f_out), 32'(P_DRAIN));
    step();
    check("halted_fwd", 32'(f_out), 32'(P_HALTED));
    check("halted_nofwd", 32'(n_out), 32'(P_HALTED));
    for (int i = 0; i < 12; i++) begin
      load_use_r3(); is_Branch_Taken = i[0];
      step();
      check($sformatf("halted_hold%0d", i), 32'(f_out), 32'(P_HALTED));
    end

    // Asynchronous reset, then reset after one drain cycle.
    clear_in();
    reset = 1;
    #1;
    check("async_reset_fwd", 32'(f_out), 32'(P_IDLE));
    step();
    reset = 0;
    of_valid = 1; of_is_halt = 1;
    step();
    clear_in();
    check("rd_drain_a", 32'(f_out), 32'(P_DRAIN));
    step();
    check("rd_drain_b", 32'(f_out), 32'(P_DRAIN));
    reset = 1;
    #1;
    check("rd_reset_fwd", 32'(f_out), 32'(P_IDLE));
    check("rd_reset_nofwd", 32'(n_out), 32'(P_IDLE));
    step();
    reset = 0;
    step();
    check("rd_after_fwd", 32'(f_out), 32'(P_IDLE));

`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall_reset", 32'(f_perf_stall), 32'd0);
    check("perf_flush_reset", 32'(f_perf_flush), 32'd0);
    load_use_r3();
    repeat (3) step();
    check("perf_stall_3", 32'(f_perf_stall), 32'd3);
    is_Branch_Taken = 1;
    repeat (2) step();
    check("perf_flush_2", 32'(f_perf_flush), 32'd2);
    check("perf_stall_hold", 32'(f_perf_stall), 32'd3);
    is_Branch_Taken = 0;
    repeat ((1 << CNT_W) + 5) step();
    check("perf_stall_sat", 32'(f_perf_stall), 32'((1 << CNT_W) - 1));
    check("perf_flush_keep", 32'(f_perf_flush), 32'd2);
    clear_in();
    reset = 1;
    #1;
    check("perf_stall_clr", 32'(f_perf_stall), 32'd0);
    check("perf_flush_clr", 32'(n_perf_flush), 32'd0);
    step();
    reset = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central control unit for the 5-stage pipeline (IF, OF, EX, MA, RW).
- Decides each cycle whether to stall the PC and the IF/OF latch, whether to squash IF/OF after a taken branch, and whether to inject a bubble into OF/EX.
- Sequences end-of-program drain: once the halt instruction reaches OF it is issued, fetch stops, the pipeline empties, then isLastInstruction is raised for the testbench.

Parameters:
- FORWARDING, 1, 1 = full EX/MA/RW bypass present, only load-use stalls; 0 = no bypass, stall on any EX/MA producer match.
- DRAIN_CYCLES, 3, cycles after halt issue before HALTED (EX, MA, RW).
- CNT_W, 16, width of performance counters (optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- of_valid  in  1  OF holds a real instruction.
- of_rs1  in  4  first source register of the OF instruction.
- of_rs1_used  in  1  of_rs1 is read.
- of_rs2  in  4  second source register of the OF instruction.
- of_rs2_used  in  1  of_rs2 is read.
- of_is_halt  in  1  OF instruction is the last/halt instruction.
- ex_isWb  in  1  EX instruction writes a register.
- ex_rd  in  4  EX destination register.
- ex_isLd  in  1  EX instruction is a load.
- ma_isWb  in  1  MA instruction writes a register.
- ma_rd  in  4  MA destination register.
- is_Branch_Taken  in  1  EX resolved a taken branch this cycle.
- stall_pc  out  1  hold PC.
- stall_if_of  out  1  hold IF/OF latch.
- flush_if_of  out  1  load nop into IF/OF.
- bubble_of_ex  out  1  load nop into OF/EX.
- isDataInterLock  out  1  data hazard stall active.
- isLastInstruction  out  1  program complete; sticky.
- ctrl_state  out  2  0 = RUN, 1 = DRAIN, 2 = HALTED.

Behaviour:
- Reset, asynchronous: ctrl_state = RUN, drain counter = 0, isLastInstruction = 0, all other outputs 0.
- Combinational hazard term, zero latency:
  - src_match(r) = of_valid & ((of_rs1_used & of_rs1 == r) | (of_rs2_used & of_rs2 == r)).
  - FORWARDING=1: hz = ex_isWb & ex_isLd & src_match(ex_rd).
  - FORWARDING=0: hz = (ex_isWb & src_match(ex_rd)) | (ma_isWb & src_match(ma_rd)).
  - RW is never a hazard: the register file writes in the first half-cycle.
- RUN outputs:
  - is_Branch_Taken = 1: flush_if_of = 1, bubble_of_ex = 1, stalls 0, isDataInterLock = 0. Branch overrides any hazard because the dependent instruction is squashed.
  - Otherwise, if hz: stall_pc = stall_if_of = bubble_of_ex = isDataInterLock = 1. The stall lasts as long as hz holds (1 cycle for load-use; up to 2 cycles with FORWARDING=0).
  - Otherwise all outputs 0.
- RUN to DRAIN:
  - Condition: of_is_halt & of_valid & !hz & !is_Branch_Taken at the clock edge. The halt issues to EX.
  - Counter loads DRAIN_CYCLES-1.
  - A taken branch in the same cycle squashes the halt; stay in RUN.
- DRAIN:
  - stall_pc = 1, flush_if_of = 1 every cycle; bubble_of_ex = 0, isDataInterLock = 0.
  - is_Branch_Taken and hazards are ignored; nothing younger than the halt is live.
  - Counter decrements each cycle; at 0 the next edge enters HALTED.
- HALTED:
  - stall_pc = stall_if_of = flush_if_of = 1, isLastInstruction = 1 (registered, sticky).
  - Exit only through reset.
- ctrl_state encoding 3 is illegal; recover to RUN on the next edge.
- Reset asserted mid-stall or mid-DRAIN: immediate return to reset values, no partial drain retained.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cycles [CNT_W] and perf_flush_count [CNT_W].
  - perf_stall_cycles increments each cycle isDataInterLock = 1.
  - perf_flush_count increments each RUN cycle with is_Branch_Taken = 1.
  - Both saturate at all-ones, clear on reset, and freeze in DRAIN and HALTED.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Load-use, FORWARDING=1: ex_isWb = ex_isLd = 1, ex_rd = 3; of_rs1 = 3 used.
  -> stall_pc, stall_if_of, bubble_of_ex and isDataInterLock = 1 for exactly 1 cycle, then 0 once the load moves to MA.
- ALU dependency, FORWARDING=0: ex_rd = 5 writing, of_rs2 = 5 used; bench advances EX to MA.
  -> interlock for 2 cycles.
  -> Same stimulus with FORWARDING=1: no stall.
- Branch plus hazard in the same cycle:
  -> flush_if_of = 1, bubble_of_ex = 1, stall_pc = 0, isDataInterLock = 0.
- Halt: of_is_halt = 1 in RUN.
  -> ctrl_state = 1 for 3 cycles, then 2.
  -> isLastInstruction rises on the 4th edge and stays 1 for more than 10 cycles.
- Halt in OF while is_Branch_Taken = 1:
  -> ctrl_state stays 0, flush asserted.
- Reset mid-DRAIN (after 1 drain cycle):
  -> ctrl_state = 0 and all outputs 0 immediately.
  -> With HAZARD_PERF_CNT_EN, counters = 0.
  -> Saturation check: force 2^CNT_W + 5 stall cycles -> perf_stall_cycles = all-ones.
